// File: rtl/riscv_alu_pkg.sv
// Shared RV32I ALU definitions: datapath width, ALUSel opcodes and requester ids
// used by the ALU sharing block and its arbiter.
package riscv_alu_pkg;

  localparam int XLEN  = 32;
  localparam int SEL_W = 4;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;
  localparam logic [3:0] ALU_JALR = 4'b1010;
  localparam logic [3:0] ALU_LUI  = 4'b1011;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The pointer remembers the last granted requester
// and only moves when a grant is actually issued.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  import riscv_alu_pkg::*;

  logic last_q;
  logic last_d;

  always_comb begin
    gnt = req;
    // On contention the requester that did not win last time goes first.
    if (&req) begin
      gnt = (last_q == REQ1) ? 2'b01 : 2'b10;
    end
    last_d = (|gnt) ? gnt[1] : last_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= REQ1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between two valid/ready requesters:
// grant, register operands, drive the ALU for one cycle, park result per requester.
module alu_share_arbiter #(
  parameter int XLEN  = riscv_alu_pkg::XLEN,
  parameter int SEL_W = riscv_alu_pkg::SEL_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [XLEN-1:0]  req0_a,
  input  logic [XLEN-1:0]  req0_b,
  input  logic [SEL_W-1:0] req0_sel,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [XLEN-1:0]  rsp0_data,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [XLEN-1:0]  req1_a,
  input  logic [XLEN-1:0]  req1_b,
  input  logic [SEL_W-1:0] req1_sel,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [XLEN-1:0]  rsp1_data,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [XLEN-1:0]  alu_result
);
  import riscv_alu_pkg::*;

  logic [1:0]       req_valid;
  logic [1:0]       rsp_ready;
  logic [XLEN-1:0]  req_a   [2];
  logic [XLEN-1:0]  req_b   [2];
  logic [SEL_W-1:0] req_sel [2];
  logic [1:0]       elig;
  logic [1:0]       gnt;
  logic [1:0]       issue_hit;
  logic             gid;

  logic             issue_vld_q, issue_vld_d;
  logic             issue_id_q,  issue_id_d;
  logic [XLEN-1:0]  issue_a_q,   issue_a_d;
  logic [XLEN-1:0]  issue_b_q,   issue_b_d;
  logic [SEL_W-1:0] issue_sel_q, issue_sel_d;
  logic [1:0]       rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]  rsp_data_q  [2];
  logic [XLEN-1:0]  rsp_data_d  [2];

  assign req_valid  = {req1_valid, req0_valid};
  assign rsp_ready  = {rsp1_ready, rsp0_ready};
  assign req_a[0]   = req0_a;
  assign req_a[1]   = req1_a;
  assign req_b[0]   = req0_b;
  assign req_b[1]   = req1_b;
  assign req_sel[0] = req0_sel;
  assign req_sel[1] = req1_sel;

  assign issue_hit = {issue_vld_q & issue_id_q, issue_vld_q & ~issue_id_q};

  // A requester with a parked or in-flight result stays out of arbitration,
  // so one stalled consumer never holds the ALU away from the other.
  for (genvar gi = 0; gi < 2; gi++) begin : g_elig
    assign elig[gi] = req_valid[gi] & ~rsp_valid_q[gi] & ~issue_hit[gi] & ~reset;
  end

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (elig),
    .gnt   (gnt)
  );

  assign gid = gnt[1];

  always_comb begin
    issue_vld_d = |gnt;
    issue_id_d  = issue_id_q;
    issue_a_d   = issue_a_q;
    issue_b_d   = issue_b_q;
    issue_sel_d = issue_sel_q;
    if (|gnt) begin
      issue_id_d  = gid ? REQ1 : REQ0;
      issue_a_d   = req_a[gid];
      issue_b_d   = req_b[gid];
      issue_sel_d = req_sel[gid];
    end
    for (int i = 0; i < 2; i++) begin
      rsp_valid_d[i] = rsp_valid_q[i] & ~rsp_ready[i];
      rsp_data_d[i]  = rsp_data_q[i];
      if (issue_hit[i]) begin
        rsp_valid_d[i] = 1'b1;
        rsp_data_d[i]  = alu_result;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      issue_vld_q <= 1'b0;
      issue_id_q  <= REQ0;
      issue_a_q   <= '0;
      issue_b_q   <= '0;
      issue_sel_q <= SEL_W'(ALU_ADD);
      rsp_valid_q <= '0;
      for (int i = 0; i < 2; i++) begin
        rsp_data_q[i] <= '0;
      end
    end else begin
      issue_vld_q <= issue_vld_d;
      issue_id_q  <= issue_id_d;
      issue_a_q   <= issue_a_d;
      issue_b_q   <= issue_b_d;
      issue_sel_q <= issue_sel_d;
      rsp_valid_q <= rsp_valid_d;
      for (int i = 0; i < 2; i++) begin
        rsp_data_q[i] <= rsp_data_d[i];
      end
    end
  end

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign rsp0_valid = rsp_valid_q[0];
  assign rsp1_valid = rsp_valid_q[1];
  assign rsp0_data  = rsp_data_q[0];
  assign rsp1_data  = rsp_data_q[1];
  assign alu_a      = issue_a_q;
  assign alu_b      = issue_b_q;
  assign alu_sel    = issue_sel_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: behavioural ALU, transaction-level reference model,
// directed scenarios followed by a randomized phase.
module tb_alu_share_arbiter;
  import riscv_alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0]  req0_sel = '0, req1_sel = '0;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_data, rsp1_data, alu_a, alu_b, alu_result;
  logic [3:0]  alu_sel;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: one op in flight (result computed at accept), one parked result per requester.
  bit          m_inf_v;
  int          m_inf_id;
  logic [31:0] m_inf_val;
  bit          m_held_v [2];
  logic [31:0] m_held_d [2];
  int          m_last;
  logic [31:0] m_la, m_lb;
  logic [3:0]  m_lsel;
  int          last_g;
  int          g_hist[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
    case (s)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a << b[4:0];
      4'd3:    return {31'b0, $signed(a) < $signed(b)};
      4'd4:    return {31'b0, a < b};
      4'd5:    return a ^ b;
      4'd6:    return a >> b[4:0];
      4'd7:    return $signed(a) >>> b[4:0];
      4'd8:    return a | b;
      4'd9:    return a & b;
      4'd10:   return (a + b) & ~32'd1;
      4'd11:   return b;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_result = alu_f(alu_a, alu_b, alu_sel);

  alu_share_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_sel   (req0_sel),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_data  (rsp0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_sel   (req1_sel),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_data  (rsp1_data),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered just after a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step(input bit chk_on);
    bit          e0, e1, rr0, rr1, rst;
    int          g;
    logic [31:0] ga, gb;
    logic [3:0]  gs;
    #1;
    rst = reset;
    rr0 = rsp0_ready;
    rr1 = rsp1_ready;
    e0 = req0_valid && !m_held_v[0] && !(m_inf_v && m_inf_id == 0) && !rst;
    e1 = req1_valid && !m_held_v[1] && !(m_inf_v && m_inf_id == 1) && !rst;
    if (e0 && e1)  g = (m_last == 0) ? 1 : 0;
    else if (e0)   g = 0;
    else if (e1)   g = 1;
    else           g = -1;
    if (chk_on) begin
      chk("req0_ready", req0_ready, g == 0);
      chk("req1_ready", req1_ready, g == 1);
      chk("rsp0_valid", rsp0_valid, m_held_v[0]);
      chk("rsp1_valid", rsp1_valid, m_held_v[1]);
      if (m_held_v[0]) chk("rsp0_data", rsp0_data, m_held_d[0]);
      if (m_held_v[1]) chk("rsp1_data", rsp1_data, m_held_d[1]);
      chk("alu_a", alu_a, m_la);
      chk("alu_b", alu_b, m_lb);
      chk("alu_sel", alu_sel, m_lsel);
    end
    ga = (g == 1) ? req1_a : req0_a;
    gb = (g == 1) ? req1_b : req0_b;
    gs = (g == 1) ? req1_sel : req0_sel;
    last_g = g;
    if (g >= 0) begin
      g_hist.push_back(g);
      $display("[%0t] accept req%0d sel=%h a=%h b=%h expect=%h", $time, g, gs, ga, gb, alu_f(ga, gb, gs));
    end
    @(posedge clk);
    if (rst) begin
      m_inf_v = 1'b0;
      m_held_v[0] = 1'b0;
      m_held_v[1] = 1'b0;
      m_last = 1;
      m_la = '0;
      m_lb = '0;
      m_lsel = '0;
    end else begin
      if (rr0) m_held_v[0] = 1'b0;
      if (rr1) m_held_v[1] = 1'b0;
      if (m_inf_v) begin
        m_held_v[m_inf_id] = 1'b1;
        m_held_d[m_inf_id] = m_inf_val;
      end
      m_inf_v = (g >= 0);
      if (g >= 0) begin
        m_inf_id  = g;
        m_inf_val = alu_f(ga, gb, gs);
        m_last    = g;
        m_la      = ga;
        m_lb      = gb;
        m_lsel    = gs;
      end
    end
    @(negedge clk);
  endtask

  logic [3:0]  t5_sel [3];
  logic [31:0] t5_a [3];
  logic [31:0] t5_b [3];
  logic [31:0] t5_exp [3];
  int          ones, zeros;

  initial begin
    t5_sel = '{ALU_JALR, ALU_LUI, 4'hF};
    t5_a   = '{32'h1001, 32'h0, 32'h1234_5678};
    t5_b   = '{32'h4, 32'hABCD_E000, 32'h9};
    t5_exp = '{32'h1004, 32'hABCD_E000, 32'h0};

    @(negedge clk);
    reset = 1'b1;
    step(1'b0);
    // Reset state, with requests pending to show ready stays low during reset.
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    step(1'b1);
    chk("rst_rsp0_data", rsp0_data, 32'h0);
    chk("rst_rsp1_data", rsp1_data, 32'h0);
    chk("rst_alu_sel", alu_sel, {28'h0, ALU_ADD});
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    reset = 1'b0;

    // Single ADD 5+7.
    req0_a = 32'd5; req0_b = 32'd7; req0_sel = ALU_ADD; req0_valid = 1'b1; rsp0_ready = 1'b1;
    step(1'b1);
    chk("t1_accept", last_g, 0);
    req0_valid = 1'b0;
    step(1'b1);
    chk("t1_rsp0_valid", rsp0_valid, 1'b1);
    chk("t1_rsp0_data", rsp0_data, 32'd12);
    step(1'b1);
    chk("t1_pulse", rsp0_valid, 1'b0);

    // Simultaneous requests right after reset.
    reset = 1'b1;
    step(1'b1);
    reset = 1'b0;
    req0_a = 32'd3; req0_b = 32'd5; req0_sel = ALU_SUB; req0_valid = 1'b1;
    req1_a = 32'hFFFF_FFFF; req1_b = 32'd1; req1_sel = ALU_SLT; req1_valid = 1'b1;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    step(1'b1);
    chk("t2_first_gnt", last_g, 0);
    req0_valid = 1'b0;
    step(1'b1);
    chk("t2_second_gnt", last_g, 1);
    chk("t2_rsp0_data", rsp0_data, 32'hFFFF_FFFE);
    req1_valid = 1'b0;
    step(1'b1);
    chk("t2_rsp1_valid", rsp1_valid, 1'b1);
    chk("t2_rsp1_data", rsp1_data, 32'd1);
    step(1'b1);

    // Backpressure on requester 0 must not stall requester 1.
    rsp0_ready = 1'b0;
    req0_a = 32'd1; req0_b = 32'd2; req0_sel = ALU_ADD; req0_valid = 1'b1;
    req1_a = 32'hF0F0; req1_b = 32'h0FF0; req1_sel = ALU_XOR; req1_valid = 1'b1;
    step(1'b1);
    chk("t3_req0_first", last_g, 0);
    g_hist.delete();
    for (int k = 0; k < 6; k++) begin
      step(1'b1);
      if (rsp1_valid) chk("t3_xor", rsp1_data, 32'hFF00);
    end
    ones = 0; zeros = 0;
    foreach (g_hist[k]) begin
      if (g_hist[k] == 1) ones++; else zeros++;
    end
    chk("t3_req1_grants", ones, 2);
    chk("t3_req0_blocked", zeros, 0);
    rsp0_ready = 1'b1;
    step(1'b1);
    step(1'b1);
    chk("t3_req0_after_drain", last_g, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int k = 0; k < 3; k++) step(1'b1);

    // Both continuously valid for 10 cycles.
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    g_hist.delete();
    for (int k = 0; k < 10; k++) step(1'b1);
    chk("t4_grant_count", g_hist.size() >= 6, 1'b1);
    for (int k = 1; k < g_hist.size(); k++) begin
      chk("t4_alternate", g_hist[k] != g_hist[k-1], 1'b1);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int k = 0; k < 3; k++) step(1'b1);

    // JALR, LUI and an unassigned opcode.
    for (int k = 0; k < 3; k++) begin
      req0_a = t5_a[k]; req0_b = t5_b[k]; req0_sel = t5_sel[k]; req0_valid = 1'b1;
      step(1'b1);
      req0_valid = 1'b0;
      step(1'b1);
      chk("t5_rsp0_data", rsp0_data, t5_exp[k]);
      step(1'b1);
    end

    // Reset while an op is in flight and a result is parked on requester 1.
    rsp1_ready = 1'b0;
    req1_a = 32'd10; req1_b = 32'd20; req1_sel = ALU_ADD; req1_valid = 1'b1;
    step(1'b1);
    req1_valid = 1'b0;
    step(1'b1);
    req0_a = 32'd9; req0_b = 32'd4; req0_sel = ALU_SUB; req0_valid = 1'b1;
    step(1'b1);
    chk("t6_rsp1_parked", rsp1_valid, 1'b1);
    req0_valid = 1'b0;
    reset = 1'b1;
    step(1'b1);
    chk("t6_rsp0_valid", rsp0_valid, 1'b0);
    chk("t6_rsp1_valid", rsp1_valid, 1'b0);
    chk("t6_alu_sel", alu_sel, {28'h0, ALU_ADD});
    reset = 1'b0;
    rsp1_ready = 1'b1;
    req1_a = 32'h0; req1_b = 32'h5555_0000; req1_sel = ALU_LUI; req1_valid = 1'b1;
    step(1'b1);
    chk("t6_req1_after_reset", last_g, 1);
    req1_valid = 1'b0;
    step(1'b1);
    chk("t6_rsp1_data", rsp1_data, 32'h5555_0000);
    step(1'b1);

    // Randomized traffic, including occasional resets.
    for (int k = 0; k < 400; k++) begin
      req0_valid = ($urandom_range(0, 9) < 7);
      req1_valid = ($urandom_range(0, 9) < 7);
      req0_a = $urandom; req0_b = $urandom; req0_sel = 4'($urandom_range(0, 15));
      req1_a = $urandom; req1_b = $urandom; req1_sel = 4'($urandom_range(0, 15));
      rsp0_ready = ($urandom_range(0, 9) < 6);
      rsp1_ready = ($urandom_range(0, 9) < 6);
      reset = ($urandom_range(0, 59) == 0);
      step(1'b1);
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
